// File: rtl/note_sched_pkg.sv
// Shared types and constants for the note scheduler: FSM states, ROM word layout and
// source encodings.
package note_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StWaitTx,
        StHold,
        StGap
    } state_e;

    localparam logic [11:0] END_MARKER = 12'h000;

    localparam int unsigned DUR_MSB  = 11;
    localparam int unsigned DUR_LSB  = 8;
    localparam int unsigned NOTE_MSB = 7;
    localparam int unsigned NOTE_LSB = 0;

    localparam logic SRC_KEY = 1'b0;
    localparam logic SRC_ROM = 1'b1;

endpackage

// File: rtl/note_scheduler_if.sv
// Note byte handshake between the scheduler (master) and the UART sender (slave).
interface note_scheduler_if;

    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx_stop;

    modport master (
        output tx_en,
        output tx_data,
        input  tx_stop
    );

    modport slave (
        input  tx_en,
        input  tx_data,
        output tx_stop
    );

endinterface

// File: rtl/note_scheduler_tick_prescaler.sv
// Divides clk_i down to a one-cycle tick every TICK_DIV cycles; clr_i restarts the count
// so the next tick lands exactly TICK_DIV cycles later.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 2500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        if (clr_i || (cnt_q == CntMax)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    assign tick_o = (cnt_q == CntMax);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/note_scheduler.sv
// Schedules keypad and melody-ROM notes onto the shared UART/buzzer path; keypad pre-empts ROM.
// Define NOTE_SCHED_LOOP_EN to make the ROM end marker wrap to address 0 instead of stopping.
module note_scheduler
    import note_sched_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 2500000,
    parameter int unsigned KEY_TICKS = 4,
    parameter int unsigned GAP_TICKS = 1,
    parameter int unsigned ADDR_W    = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              key_valid_i,
    input  logic [7:0]        key_code_i,
    input  logic              play_i,
    input  logic              stop_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [11:0]       rom_data_i,
    note_scheduler_if.master  tx_if,
    output logic [7:0]        note_out_o,
    output logic              src_o,
    output logic              busy_o,
    output logic              key_drop_o
);

    localparam int unsigned TickMax0 = (KEY_TICKS > GAP_TICKS) ? KEY_TICKS : GAP_TICKS;
    localparam int unsigned TickMax  = (TickMax0 > 16) ? TickMax0 : 16;
    localparam int unsigned TcntW    = $clog2(TickMax + 1);

    state_e             state_q, state_d;
    logic               fetch_rd_q, fetch_rd_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         note_q, note_d;
    logic [3:0]         dur_q, dur_d;
    logic               src_q, src_d;
    logic [7:0]         note_out_q, note_out_d;
    logic [TcntW-1:0]   tcnt_q, tcnt_d;
    logic               playing_q, playing_d;
    logic               restart_q, restart_d;
    logic               pend_valid_q, pend_valid_d;
    logic [7:0]         pend_code_q, pend_code_d;
    logic               key_drop_q, key_drop_d;

    logic               tick, presc_clr;
    logic               take_key, go_fetch0;
    logic               run, rom_abort, rom_restart;
    logic [TcntW-1:0]   limit;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (presc_clr),
        .tick_o (tick)
    );

    assign run         = playing_q & ~stop_i;
    assign rom_abort   = (src_q == SRC_ROM) & ~run;
    assign rom_restart = (src_q == SRC_ROM) & restart_q;
    assign limit       = (src_q == SRC_KEY) ? TcntW'(KEY_TICKS) :
                         (dur_q == 4'd0)    ? TcntW'(16) : TcntW'(dur_q);

    always_comb begin
        state_d    = state_q;
        fetch_rd_d = 1'b0;
        addr_d     = addr_q;
        note_d     = note_q;
        dur_d      = dur_q;
        src_d      = src_q;
        note_out_d = note_out_q;
        tcnt_d     = tcnt_q;
        playing_d  = playing_q;
        restart_d  = restart_q;
        presc_clr  = 1'b0;
        take_key   = 1'b0;
        go_fetch0  = 1'b0;

        // stop beats play; a play not consumed directly is replayed from address 0 later
        if (stop_i) begin
            playing_d = 1'b0;
            restart_d = 1'b0;
        end else if (play_i) begin
            playing_d = 1'b1;
            restart_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (pend_valid_q) begin
                    take_key = 1'b1;
                end else if (play_i && !stop_i) begin
                    go_fetch0 = 1'b1;
                end
            end
            StFetch: begin
                if (!run) begin
                    state_d = StIdle;
                end else if (restart_q) begin
                    go_fetch0 = 1'b1;
                end else if (!fetch_rd_q) begin
                    fetch_rd_d = 1'b1;
                end else if (rom_data_i == END_MARKER) begin
`ifdef NOTE_SCHED_LOOP_EN
                    addr_d = '0;
`else
                    state_d   = StIdle;
                    playing_d = 1'b0;
`endif
                end else begin
                    note_d  = rom_data_i[NOTE_MSB:NOTE_LSB];
                    dur_d   = rom_data_i[DUR_MSB:DUR_LSB];
                    src_d   = SRC_ROM;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StWaitTx;
            end
            StWaitTx: begin
                if (tx_if.tx_stop) begin
                    if (rom_abort) begin
                        state_d = StIdle;
                    end else if (rom_restart) begin
                        go_fetch0 = 1'b1;
                    end else begin
                        state_d    = StHold;
                        note_out_d = note_q;
                        presc_clr  = 1'b1;
                        tcnt_d     = '0;
                    end
                end
            end
            StHold: begin
                if (pend_valid_q) begin
                    take_key = 1'b1;
                end else if (rom_abort) begin
                    state_d    = StIdle;
                    note_out_d = '0;
                end else if (rom_restart) begin
                    go_fetch0 = 1'b1;
                end else if (tick) begin
                    if (tcnt_q == limit - TcntW'(1)) begin
                        state_d    = StGap;
                        note_out_d = '0;
                        tcnt_d     = '0;
                    end else begin
                        tcnt_d = tcnt_q + TcntW'(1);
                    end
                end
            end
            StGap: begin
                if (pend_valid_q) begin
                    take_key = 1'b1;
                end else if (rom_abort) begin
                    state_d = StIdle;
                end else if (rom_restart) begin
                    go_fetch0 = 1'b1;
                end else if (tick) begin
                    if (tcnt_q == TcntW'(GAP_TICKS - 1)) begin
                        tcnt_d = '0;
                        if (!run) begin
                            state_d = StIdle;
                        end else if (restart_q) begin
                            go_fetch0 = 1'b1;
                        end else begin
                            state_d = StFetch;
                            addr_d  = addr_q + ADDR_W'(1);
                        end
                    end else begin
                        tcnt_d = tcnt_q + TcntW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (take_key) begin
            state_d    = StIssue;
            note_d     = pend_code_q;
            src_d      = SRC_KEY;
            note_out_d = '0;
            tcnt_d     = '0;
        end
        if (go_fetch0) begin
            state_d    = StFetch;
            addr_d     = '0;
            restart_d  = 1'b0;
            note_out_d = '0;
        end
    end

    // Single-entry key buffer: latest press wins, an overwrite is reported as a drop
    always_comb begin
        pend_valid_d = pend_valid_q & ~take_key;
        pend_code_d  = pend_code_q;
        key_drop_d   = 1'b0;
        if (key_valid_i) begin
            pend_valid_d = 1'b1;
            pend_code_d  = key_code_i;
            key_drop_d   = pend_valid_q & ~take_key;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            fetch_rd_q   <= 1'b0;
            addr_q       <= '0;
            note_q       <= '0;
            dur_q        <= '0;
            src_q        <= SRC_KEY;
            note_out_q   <= '0;
            tcnt_q       <= '0;
            playing_q    <= 1'b0;
            restart_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_code_q  <= '0;
            key_drop_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_rd_q   <= fetch_rd_d;
            addr_q       <= addr_d;
            note_q       <= note_d;
            dur_q        <= dur_d;
            src_q        <= src_d;
            note_out_q   <= note_out_d;
            tcnt_q       <= tcnt_d;
            playing_q    <= playing_d;
            restart_q    <= restart_d;
            pend_valid_q <= pend_valid_d;
            pend_code_q  <= pend_code_d;
            key_drop_q   <= key_drop_d;
        end
    end

    assign tx_if.tx_en   = (state_q == StIssue) || (state_q == StWaitTx);
    assign tx_if.tx_data = note_q;
    assign rom_addr_o    = addr_q;
    assign note_out_o    = note_out_q;
    assign src_o         = src_q;
    assign busy_o        = (state_q != StIdle);
    assign key_drop_o    = key_drop_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler with a synchronous melody ROM and a UART model that
// answers tx_stop 10 cycles after tx_en rises.
module tb_note_scheduler;

    localparam int unsigned TickDiv  = 4;
    localparam int unsigned KeyTicks = 2;
    localparam int unsigned GapTicks = 1;
    localparam int unsigned AddrW    = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             key_valid = 1'b0;
    logic [7:0]       key_code = 8'h00;
    logic             play = 1'b0;
    logic             stop = 1'b0;
    logic [AddrW-1:0] rom_addr;
    logic [11:0]      rom_data;
    logic [7:0]       note_out;
    logic             src;
    logic             busy;
    logic             key_drop;
    logic [11:0]      rom [64];

    logic             ua_busy;
    logic             ua_stop;
    logic             man_stop = 1'b0;
    int               ua_cnt;
    logic             tx_en_prev;
    int               tx_rises = 0;

    int               n_checks = 0;
    int               n_errors = 0;

    note_scheduler_if tx_if ();

    note_scheduler #(
        .TICK_DIV  (TickDiv),
        .KEY_TICKS (KeyTicks),
        .GAP_TICKS (GapTicks),
        .ADDR_W    (AddrW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .key_valid_i (key_valid),
        .key_code_i  (key_code),
        .play_i      (play),
        .stop_i      (stop),
        .rom_addr_o  (rom_addr),
        .rom_data_i  (rom_data),
        .tx_if       (tx_if.master),
        .note_out_o  (note_out),
        .src_o       (src),
        .busy_o      (busy),
        .key_drop_o  (key_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    assign tx_if.tx_stop = ua_stop | man_stop;

    always @(posedge clk) begin
        if (rst) begin
            ua_busy <= 1'b0;
            ua_stop <= 1'b0;
            ua_cnt  <= 0;
        end else begin
            ua_stop <= 1'b0;
            if (tx_if.tx_en && !ua_busy && !ua_stop) begin
                ua_busy <= 1'b1;
                ua_cnt  <= 1;
            end else if (ua_busy) begin
                if (ua_cnt == 9) begin
                    ua_stop <= 1'b1;
                    ua_busy <= 1'b0;
                end
                ua_cnt <= ua_cnt + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            tx_en_prev <= 1'b0;
        end else begin
            tx_en_prev <= tx_if.tx_en;
            if (tx_if.tx_en && !tx_en_prev) tx_rises <= tx_rises + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic go(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_key(input logic [7:0] code);
        key_valid = 1'b1;
        key_code  = code;
        go(1);
        key_valid = 1'b0;
    endtask

    task automatic pulse_play();
        play = 1'b1;
        go(1);
        play = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        go(1);
        stop = 1'b0;
    endtask

    task automatic count_note(input logic [7:0] v, output int n);
        n = 0;
        while (note_out == v && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int i;
        i = 0;
        while (busy && i < budget) begin
            i++;
            @(negedge clk);
        end
        check_val(tag, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int r0;
        for (int i = 0; i < 64; i++) rom[i] = 12'h000;
        rom[0] = 12'h241;
        rom[1] = 12'h142;
        rom[2] = 12'h000;

        // Reset state
        go(2);
        check_val("rst tx_en", tx_if.tx_en, 1'b0);
        check_val("rst note_out", note_out, 8'h00);
        check_val("rst busy", busy, 1'b0);
        check_val("rst rom_addr", rom_addr, 6'd0);
        check_val("rst key_drop", key_drop, 1'b0);
        check_val("rst tx_data", tx_if.tx_data, 8'h00);
        rst = 1'b0;
        go(1);

        // 1: keypad note from idle
        pulse_key(8'h31);
        check_val("t1 tx_en t+1", tx_if.tx_en, 1'b0);
        go(1);
        check_val("t1 tx_en t+2", tx_if.tx_en, 1'b1);
        check_val("t1 tx_data", tx_if.tx_data, 8'h31);
        check_val("t1 src", src, 1'b0);
        go(10);
        check_val("t1 tx_en held", tx_if.tx_en, 1'b1);
        check_val("t1 silent in tx", note_out, 8'h00);
        go(1);
        check_val("t1 tx_en drop", tx_if.tx_en, 1'b0);
        count_note(8'h31, n);
        check_val("t1 hold len", n, 8);
        go(3);
        check_val("t1 gap busy", busy, 1'b1);
        go(1);
        check_val("t1 idle", busy, 1'b0);

        // 2: ROM playback 0x41, 0x42, end marker
        go(1);
        pulse_play();
        check_val("t2 addr0", rom_addr, 6'd0);
        check_val("t2 busy", busy, 1'b1);
        go(1);
        check_val("t2 tx_en p+2", tx_if.tx_en, 1'b0);
        go(1);
        check_val("t2 tx_en p+3", tx_if.tx_en, 1'b1);
        check_val("t2 tx_data 41", tx_if.tx_data, 8'h41);
        check_val("t2 src rom", src, 1'b1);
        go(11);
        count_note(8'h41, n);
        check_val("t2 hold 41", n, 8);
        go(3);
        check_val("t2 gap addr", rom_addr, 6'd0);
        go(1);
        check_val("t2 next addr", rom_addr, 6'd1);
        go(2);
        check_val("t2 tx_en 42", tx_if.tx_en, 1'b1);
        check_val("t2 tx_data 42", tx_if.tx_data, 8'h42);
        go(11);
        count_note(8'h42, n);
        check_val("t2 hold 42", n, 4);
        go(4);
        check_val("t2 end addr", rom_addr, 6'd2);
        go(1);
        check_val("t2 busy at end", busy, 1'b1);
        go(1);
`ifdef NOTE_SCHED_LOOP_EN
        check_val("t2 loop addr", rom_addr, 6'd0);
        check_val("t2 loop busy", busy, 1'b1);
        go(2);
        check_val("t2 loop tx 41", tx_if.tx_data, 8'h41);
        pulse_stop();
        wait_idle("t2 loop stop", 60);
`else
        check_val("t2 idle", busy, 1'b0);
`endif

        // 3: key pre-empts ROM note, playback resumes at the next address
        go(2);
        pulse_play();
        go(14);
        pulse_key(8'h35);
        check_val("t3 41 still", note_out, 8'h41);
        go(1);
        check_val("t3 41 cut", note_out, 8'h00);
        check_val("t3 key tx_en", tx_if.tx_en, 1'b1);
        check_val("t3 key data", tx_if.tx_data, 8'h35);
        check_val("t3 key src", src, 1'b0);
        go(11);
        count_note(8'h35, n);
        check_val("t3 key hold", n, 8);
        go(4);
        check_val("t3 resume addr", rom_addr, 6'd1);
        go(2);
        check_val("t3 tx 42", tx_if.tx_data, 8'h42);
        check_val("t3 tx_en 42", tx_if.tx_en, 1'b1);
        pulse_stop();
        wait_idle("t3 stop idle", 60);

        // 4: two keys during WAIT_TX, latest wins
        go(2);
        r0 = tx_rises;
        pulse_key(8'h33);
        go(1);
        check_val("t4 tx 33", tx_if.tx_data, 8'h33);
        go(2);
        pulse_key(8'h31);
        check_val("t4 no drop", key_drop, 1'b0);
        go(1);
        pulse_key(8'h32);
        check_val("t4 drop", key_drop, 1'b1);
        go(1);
        check_val("t4 drop pulse", key_drop, 1'b0);
        go(5);
        check_val("t4 33 sounds", note_out, 8'h33);
        go(1);
        check_val("t4 tx_en 32", tx_if.tx_en, 1'b1);
        check_val("t4 tx 32", tx_if.tx_data, 8'h32);
        check_val("t4 33 cut", note_out, 8'h00);
        wait_idle("t4 idle", 60);
        check_val("t4 byte count", tx_rises - r0, 2);

        // 5: play and stop together
        go(2);
        r0 = tx_rises;
        play = 1'b1;
        stop = 1'b1;
        go(1);
        play = 1'b0;
        stop = 1'b0;
        check_val("t5 busy", busy, 1'b0);
        go(4);
        check_val("t5 busy later", busy, 1'b0);
        check_val("t5 no tx", tx_rises - r0, 0);

        // dur field 0 holds for 16 ticks
        rom[0] = 12'h043;
        rom[1] = 12'h000;
        go(1);
        pulse_play();
        go(2);
        check_val("dur0 tx 43", tx_if.tx_data, 8'h43);
        go(11);
        count_note(8'h43, n);
        check_val("dur0 hold", n, 64);
        pulse_stop();
        wait_idle("dur0 idle", 60);

        // 6: reset during WAIT_TX with a key pending
        go(2);
        pulse_key(8'h36);
        go(1);
        check_val("t6 tx_en", tx_if.tx_en, 1'b1);
        go(2);
        pulse_key(8'h37);
        rst = 1'b1;
        go(1);
        rst = 1'b0;
        check_val("t6 rst tx_en", tx_if.tx_en, 1'b0);
        check_val("t6 rst note", note_out, 8'h00);
        check_val("t6 rst busy", busy, 1'b0);
        go(2);
        man_stop = 1'b1;
        go(1);
        man_stop = 1'b0;
        check_val("t6 stray stop busy", busy, 1'b0);
        check_val("t6 stray stop tx_en", tx_if.tx_en, 1'b0);
        go(2);
        check_val("t6 key cleared", busy, 1'b0);
        check_val("t6 note", note_out, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
